// File: rtl/shift_pkg.sv
// Shared constants for the parametrised universal shift register:
// operation codes, shift directions and frame FSM state encoding.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD   = 3'd0;
  localparam logic [2:0] MODE_LOAD   = 3'd1;
  localparam logic [2:0] MODE_SHIFT  = 3'd2;
  localparam logic [2:0] MODE_ROTATE = 3'd3;
  localparam logic [2:0] MODE_ARITH  = 3'd4;
  localparam logic [2:0] MODE_FRAME  = 3'd5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

endpackage

// File: rtl/param_shift_register_if.sv
// Control/data bundle between a tester (master) and the shift register (slave).
interface param_shift_register_if #(
  parameter int WIDTH = 8
);

  // Frame handshake: the master issues a frame with modo=FRAME while busy is
  // low; busy stays high for the whole transfer, and done pulses for exactly
  // one cycle when it completes. A new frame may be accepted in that same
  // done cycle.
  logic             enb;
  logic             dir;
  logic             s_in;
  logic [2:0]       modo;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             s_out;
  logic             busy;
  logic             done;
  logic [0:0]       state;

  modport master (
    output enb, dir, s_in, modo, d,
    input  q, s_out, busy, done, state
  );

  modport slave (
    input  enb, dir, s_in, modo, d,
    output q, s_out, busy, done, state
  );

endinterface

// File: rtl/shift_frame_ctrl.sv
// Frame sequencer: owns the IDLE/FRAME FSM, the frame bit counter, the latched
// frame direction and the busy/done flags; strobes the datapath once per frame bit.
module shift_frame_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enb,
  input  logic       dir,
  input  logic [2:0] modo,
  output logic       frame_shift,
  output logic       frame_dir,
  output logic       busy,
  output logic       done,
  output logic [0:0] state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  assign frame_shift = (state == ST_FRAME) && enb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      frame_dir <= DIR_LEFT;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // done is a single-cycle pulse independent of the clock enable
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enb && modo == MODE_FRAME) begin
            state     <= ST_FRAME;
            cnt       <= '0;
            frame_dir <= dir;
            busy      <= 1'b1;
          end
        end
        ST_FRAME: begin
          if (enb) begin
            if (cnt == LAST) begin
              state <= ST_IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/param_shift_register.sv
// Parametrised universal shift register: load, shift, rotate, arithmetic shift
// and a self-timed WIDTH-bit serial frame with busy/done signalling.
module param_shift_register
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  param_shift_register_if.slave  bus
);

  logic [WIDTH-1:0] q_r;
  logic             s_out_r;
  logic             frame_shift;
  logic             frame_dir;
  logic             busy;
  logic             done;
  logic [0:0]       state;

  shift_frame_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk         (clk),
    .reset_n     (reset_n),
    .enb         (bus.enb),
    .dir         (bus.dir),
    .modo        (bus.modo),
    .frame_shift (frame_shift),
    .frame_dir   (frame_dir),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r     <= '0;
      s_out_r <= 1'b0;
    end else if (frame_shift) begin
      // frame bits always use the direction captured when the frame started
      if (frame_dir == DIR_LEFT) begin
        q_r     <= {q_r[WIDTH-2:0], bus.s_in};
        s_out_r <= q_r[WIDTH-1];
      end else begin
        q_r     <= {bus.s_in, q_r[WIDTH-1:1]};
        s_out_r <= q_r[0];
      end
    end else if (state == ST_IDLE && bus.enb) begin
      case (bus.modo)
        MODE_LOAD, MODE_FRAME: q_r <= bus.d;
        MODE_SHIFT: begin
          if (bus.dir == DIR_LEFT) begin
            q_r     <= {q_r[WIDTH-2:0], bus.s_in};
            s_out_r <= q_r[WIDTH-1];
          end else begin
            q_r     <= {bus.s_in, q_r[WIDTH-1:1]};
            s_out_r <= q_r[0];
          end
        end
        MODE_ROTATE: begin
          if (bus.dir == DIR_LEFT) begin
            q_r     <= {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            s_out_r <= q_r[WIDTH-1];
          end else begin
            q_r     <= {q_r[0], q_r[WIDTH-1:1]};
            s_out_r <= q_r[0];
          end
        end
        MODE_ARITH: begin
          if (bus.dir == DIR_LEFT) begin
            q_r     <= {q_r[WIDTH-2:0], 1'b0};
            s_out_r <= q_r[WIDTH-1];
          end else begin
            q_r     <= {q_r[WIDTH-1], q_r[WIDTH-1:1]};
            s_out_r <= q_r[0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.q     = q_r;
  assign bus.s_out = s_out_r;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.state = state;

endmodule

// File: tb/tb_param_shift_register.sv
// Directed bench for param_shift_register at WIDTH=8: reset, rotate, arithmetic
// shift, serial frames with pause, back-to-back frames and mid-frame reset.
module tb_param_shift_register;

  localparam int WIDTH = 8;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  param_shift_register_if #(.WIDTH(WIDTH)) bus ();

  param_shift_register #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // inputs change 1 time unit after the rising edge, outputs are read there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic enb, input logic [2:0] modo, input logic dir,
                       input logic s_in, input logic [7:0] d);
    bus.enb  = enb;
    bus.modo = modo;
    bus.dir  = dir;
    bus.s_in = s_in;
    bus.d    = d;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
    #2;
    total++;
    if (bus.q !== 8'h00 || bus.s_out !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.state !== 1'b0) begin
      bad++;
      $display("FAIL reset_init: q=%h s_out=%b busy=%b done=%b state=%b, want 00 0 0 0 0",
               bus.q, bus.s_out, bus.busy, bus.done, bus.state);
    end
    tick();
    reset_n = 1'b1;
    // get s_out=1 and a nonzero q, then assert reset between edges
    drive(1'b1, 3'd1, 1'b0, 1'b0, 8'h81);
    tick();
    drive(1'b1, 3'd2, 1'b0, 1'b0, 8'h00);
    tick();
    total++;
    if (bus.q !== 8'h02 || bus.s_out !== 1'b1) begin
      bad++;
      $display("FAIL shift_left: q=%h s_out=%b, want 02 1", bus.q, bus.s_out);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.q !== 8'h00 || bus.s_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: q=%h s_out=%b busy=%b done=%b, want 00 0 0 0",
               bus.q, bus.s_out, bus.busy, bus.done);
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_rotate();
    drive(1'b1, 3'd1, 1'b0, 1'b0, 8'hA5);
    tick();
    total++;
    if (bus.q !== 8'hA5) begin
      bad++;
      $display("FAIL load_a5: q=%h, want a5", bus.q);
    end
    drive(1'b1, 3'd3, 1'b1, 1'b0, 8'h00);
    tick();
    total++;
    if (bus.q !== 8'hD2 || bus.s_out !== 1'b1) begin
      bad++;
      $display("FAIL rotate_right: q=%h s_out=%b, want d2 1", bus.q, bus.s_out);
    end
    drive(1'b0, 3'd1, 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (bus.q !== 8'hD2 || bus.s_out !== 1'b1) begin
        bad++;
        $display("FAIL enb_hold[%0d]: q=%h s_out=%b, want d2 1", i, bus.q, bus.s_out);
      end
    end
  endtask

  task automatic test_arith();
    logic [7:0] exp_q [3];
    logic       exp_s [3];
    exp_q = '{8'hC0, 8'hE0, 8'hC0};
    exp_s = '{1'b0, 1'b0, 1'b1};
    drive(1'b1, 3'd1, 1'b0, 1'b0, 8'h80);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd4, (i < 2) ? 1'b1 : 1'b0, 1'b1, 8'h00);
      tick();
      total++;
      if (bus.q !== exp_q[i] || bus.s_out !== exp_s[i]) begin
        bad++;
        $display("FAIL arith[%0d]: q=%h s_out=%b, want %h %b",
                 i, bus.q, bus.s_out, exp_q[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_frame();
    logic [7:0] bits;
    logic [7:0] s_exp;
    logic [7:0] exp_q;
    bits  = 8'b1010_1010;   // bits[7-i] is the bit sent on shift i
    s_exp = 8'b0011_1100;   // s_exp[7-i] is s_out after shift i
    exp_q = 8'h3C;
    // s_out is 1 from the previous arithmetic left shift and must be untouched
    drive(1'b1, 3'd5, 1'b0, 1'b0, 8'h3C);
    tick();
    total++;
    if (bus.q !== 8'h3C || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
        bus.s_out !== 1'b1 || bus.state !== 1'b1) begin
      bad++;
      $display("FAIL frame_accept: q=%h busy=%b done=%b s_out=%b state=%b, want 3c 1 0 1 1",
               bus.q, bus.busy, bus.done, bus.s_out, bus.state);
    end
    for (int i = 0; i < 8; i++) begin
      // modo, d and dir are junk during the frame, including a repeated FRAME
      drive(1'b1, 3'((i % 6) + 1), i[0], bits[7-i], 8'hFF);
      tick();
      exp_q = {exp_q[6:0], bits[7-i]};
      total++;
      if (bus.q !== exp_q || bus.s_out !== s_exp[7-i] ||
          bus.busy !== (i != 7) || bus.done !== (i == 7)) begin
        bad++;
        $display("FAIL frame_shift[%0d]: q=%h s_out=%b busy=%b done=%b, want %h %b %b %b",
                 i, bus.q, bus.s_out, bus.busy, bus.done, exp_q, s_exp[7-i], i != 7, i == 7);
      end
    end
    total++;
    if (bus.q !== 8'hAA) begin
      bad++;
      $display("FAIL frame_final: q=%h, want aa", bus.q);
    end
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
    tick();
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 8'hAA) begin
      bad++;
      $display("FAIL done_clear: done=%b busy=%b q=%h, want 0 0 aa", bus.done, bus.busy, bus.q);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    int         sent;
    bits = 8'b1010_1010;
    sent = 0;
    drive(1'b1, 3'd5, 1'b0, 1'b0, 8'h3C);
    tick();
    // 11 edges: 8 shifts with a 3-edge pause after the 4th shift
    for (int i = 0; i < 11; i++) begin
      if (i >= 4 && i < 7) begin
        drive(1'b0, 3'd0, 1'b1, 1'b0, 8'h00);
      end else begin
        drive(1'b1, 3'd0, 1'b1, bits[7-sent], 8'h00);
        sent++;
      end
      tick();
      if (i >= 4 && i < 7) begin
        total++;
        if (bus.q !== 8'hCA || bus.busy !== 1'b1) begin
          bad++;
          $display("FAIL pause[%0d]: q=%h busy=%b, want ca 1", i, bus.q, bus.busy);
        end
      end
      total++;
      if (bus.done !== (i == 10) || bus.busy !== (i != 10)) begin
        bad++;
        $display("FAIL pause_done[%0d]: done=%b busy=%b, want %b %b",
                 i, bus.done, bus.busy, i == 10, i != 10);
      end
    end
    total++;
    if (bus.q !== 8'hAA) begin
      bad++;
      $display("FAIL pause_final: q=%h, want aa", bus.q);
    end
    // accept a new right-going frame in the done cycle
    drive(1'b1, 3'd5, 1'b1, 1'b1, 8'h81);
    tick();
    total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.q !== 8'h81) begin
      bad++;
      $display("FAIL b2b_accept: busy=%b done=%b q=%h, want 1 0 81", bus.busy, bus.done, bus.q);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'd0, 1'b0, 1'b1, 8'h00);
      tick();
    end
    total++;
    if (bus.q !== 8'hFF || bus.s_out !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_final: q=%h s_out=%b done=%b busy=%b, want ff 1 1 0",
               bus.q, bus.s_out, bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_midframe();
    drive(1'b1, 3'd5, 1'b0, 1'b0, 8'h3C);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd0, 1'b0, 1'b1, 8'h00);
      tick();
    end
    total++;
    if (bus.q !== 8'hCF || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL midframe_q: q=%h busy=%b, want cf 1", bus.q, bus.busy);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.q !== 8'h00 || bus.state !== 1'b0) begin
      bad++;
      $display("FAIL midframe_reset: busy=%b done=%b q=%h state=%b, want 0 0 00 0",
               bus.busy, bus.done, bus.q, bus.state);
    end
    tick();
    reset_n = 1'b1;
    drive(1'b1, 3'd0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL no_done[%0d]: done=%b busy=%b, want 0 0", i, bus.done, bus.busy);
      end
    end
    drive(1'b1, 3'd1, 1'b0, 1'b0, 8'h5A);
    tick();
    total++;
    if (bus.q !== 8'h5A) begin
      bad++;
      $display("FAIL load_5a: q=%h, want 5a", bus.q);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_rotate();
    test_arith();
    test_frame();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
